// File: rtl/dbnc_pkg.sv
// Shared types and parameter checks for the debounce/edge-detect block.
package dbnc_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } dbnc_state_e;

    localparam int DBNC_CNT_W = 16;

    function automatic bit dbnc_params_ok(input int stable_cycles,
                                          input int cnt_w);
        longint unsigned lim;
        lim = 64'd1 << cnt_w;
        return (stable_cycles >= 1) && (longint'(stable_cycles) < lim);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, sync active-high reset.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// Debounced level plus rise/fall pulses from an asynchronous input.
// DEBOUNCE_FALL_PULSE_EN builds the fall_o pulse register; otherwise fall_o is 0.
module debounce_edge
    import dbnc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = DBNC_CNT_W,
    parameter bit RST_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam dbnc_state_e RST_STATE = RST_LEVEL ? STABLE_HI : STABLE_LO;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam bit SKIP = (STABLE_CYCLES == 1);

    if (!dbnc_params_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_params
        $error("debounce_edge: STABLE_CYCLES out of range for CNT_W");
    end

    dbnc_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic s2;
    logic level_d, rise_d, busy_d;

    sync_2ff #(.RST_VAL(RST_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_i),
        .q   (s2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: if (s2) begin
                if (SKIP) begin
                    state_d = STABLE_HI;
                end else begin
                    state_d = PEND_HI;
                    cnt_d   = ONE;
                end
            end
            PEND_HI: begin
                if (!s2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STABLE_HI: if (!s2) begin
                if (SKIP) begin
                    state_d = STABLE_LO;
                end else begin
                    state_d = PEND_LO;
                    cnt_d   = ONE;
                end
            end
            PEND_LO: begin
                if (s2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses fire only on completed changes, never on glitch aborts.
    always_comb begin
        level_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
        busy_d  = (state_d == PEND_HI) || (state_d == PEND_LO);
        rise_d  = (state_d == STABLE_HI) &&
                  ((state_q == STABLE_LO) || (state_q == PEND_HI));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            level_o <= RST_LEVEL;
            rise_o  <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_o <= level_d;
            rise_o  <= rise_d;
            busy_o  <= busy_d;
        end
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= (state_d == STABLE_LO) &&
                      ((state_q == STABLE_HI) || (state_q == PEND_LO));
        end
    end

    assign fall_o = fall_q;
`else
    assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: vector table + scoreboard queue.
module tb_debounce_edge;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam logic F = 1'b1;
`else
    localparam logic F = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, raw_a, lvl_a, rise_a, fall_a, busy_a;
    logic rst_b, raw_b, lvl_b, rise_b, fall_b, busy_b;

    int tests = 0;
    int fails = 0;

    vec_t vt[$];
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(4), .CNT_W(16), .RST_LEVEL(1'b0)) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .raw_i   (raw_a),
        .level_o (lvl_a),
        .rise_o  (rise_a),
        .fall_o  (fall_a),
        .busy_o  (busy_a)
    );

    debounce_edge #(.STABLE_CYCLES(1), .CNT_W(4), .RST_LEVEL(1'b1)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .raw_i   (raw_b),
        .level_o (lvl_b),
        .rise_o  (rise_b),
        .fall_o  (fall_b),
        .busy_o  (busy_b)
    );

    function automatic void add(input logic r, input logic d,
                                input logic l, input logic ri,
                                input logic fa, input logic b);
        vec_t v;
        v.rst = r;
        v.raw = d;
        v.exp = {l, ri, fa, b};
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got lvl/rise/fall/busy=%b, expected %b",
                     name, act, exp);
        end
    endtask

    task automatic step_b(input logic r, input logic d, input logic [3:0] exp,
                          input string name);
        rst_b = r;
        raw_b = d;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        check(name, {lvl_b, rise_b, fall_b, busy_b}, sb.pop_front());
    endtask

    initial begin
        rst_a = 1'b1;
        raw_a = 1'b1;
        rst_b = 1'b1;
        raw_b = 1'b1;

        // reset with raw high
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // clean rise: raw high before vector 5
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        // clean fall
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, F, 0);
        add(0, 0, 0, 0, 0, 0);
        // two-cycle glitch
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // toggling every cycle
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // reset while cnt==2, then full re-debounce
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            rst_a = vt[i].rst;
            raw_a = vt[i].raw;
            sb.push_back(vt[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {lvl_a, rise_a, fall_a, busy_a}, sb.pop_front());
        end
        rst_a = 1'b1;

        // STABLE_CYCLES=1, RST_LEVEL=1
        step_b(1, 1, 4'b1000, "b_rst0");
        step_b(1, 1, 4'b1000, "b_rst1");
        step_b(0, 1, 4'b1000, "b_idle0");
        step_b(0, 1, 4'b1000, "b_idle1");
        step_b(0, 0, 4'b1000, "b_fall_n0");
        step_b(0, 0, 4'b1000, "b_fall_n1");
        step_b(0, 0, {1'b0, 1'b0, F, 1'b0}, "b_fall_n2");
        step_b(0, 0, 4'b0000, "b_fall_n3");
        step_b(0, 1, 4'b0000, "b_rise_n0");
        step_b(0, 1, 4'b0000, "b_rise_n1");
        step_b(0, 1, 4'b1100, "b_rise_n2");
        step_b(0, 1, 4'b1000, "b_rise_n3");
        step_b(0, 0, 4'b1000, "b_rst_pend0");
        step_b(1, 0, 4'b1000, "b_rst_pend1");
        step_b(0, 1, 4'b1000, "b_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
